// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM states, error codes and divisor width.
package uart_pkg;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned ERR_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        CALC
    } ab_state_t;

    localparam logic [ERR_W-1:0] ERR_NONE     = 2'b00;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [ERR_W-1:0] ERR_MISMATCH = 2'b10;
    localparam logic [ERR_W-1:0] ERR_RANGE    = 2'b11;

endpackage

// File: rtl/rx_sync_filter.sv
// RX line conditioning: 2-FF synchronizer, 3-sample majority filter and a
// registered falling-edge pulse on the filtered level.
module rx_sync_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic [2:0] samp_q;
    logic       filt_q;
    logic       maj;

    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // Everything resets to the idle-high line level so reset never produces an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            samp_q <= 3'b111;
            filt_q <= 1'b1;
            fall_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            samp_q <= {samp_q[1:0], sync_q[1]};
            filt_q <= maj;
            fall_o <= filt_q & ~maj;
        end
    end

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Baud divisor controller: measures a 0x55 sync character or takes a software
// divisor, and drives the generator's divisor with a one-cycle reload strobe.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OSR         = 16,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned DEFAULT_DIV = 54,
    parameter int unsigned TOL_SHIFT   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             rx_i,
    input  logic             sw_we_i,
    input  logic [DIV_W-1:0] sw_div_i,
    output logic [DIV_W-1:0] divisor_o,
    output logic             div_load_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_code_o
);

    localparam int unsigned SUM_W  = CNT_W + 2;
    localparam int unsigned RND_W  = SUM_W + 1;
    localparam int unsigned DIV_SH = 3 + $clog2(OSR);
    localparam int unsigned WIDE_W = (RND_W > DIV_W) ? RND_W : DIV_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ab_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] iv0_q, iv0_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [1:0]       idx_q, idx_d;
    logic [DIV_W-1:0] divisor_d;
    logic             load_d, busy_d, locked_d, err_d;
    logic [ERR_W-1:0] code_d;

    logic             fall;
    logic [CNT_W-1:0] cnt_inc, diff, tol;
    logic [RND_W-1:0] rnd;
    logic [WIDE_W-1:0] div_wide;
    logic             div_bad;

    rx_sync_filter u_rx_sync_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx_i),
        .fall_o (fall)
    );

    // The edge cycle itself is counted, so the latched interval is the true clk count.
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign diff     = (cnt_inc >= iv0_q) ? (cnt_inc - iv0_q) : (iv0_q - cnt_inc);
    assign tol      = iv0_q >> TOL_SHIFT;
    assign rnd      = RND_W'(sum_q) + RND_W'(4 * OSR);
    assign div_wide = WIDE_W'(rnd >> DIV_SH);
    assign div_bad  = (div_wide == '0) || ((div_wide >> DIV_W) != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        iv0_d     = iv0_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        divisor_d = divisor_o;
        load_d    = 1'b0;
        locked_d  = locked_o;
        err_d     = err_o;
        code_d    = err_code_o;

        case (state_q)
            IDLE: ;
            ARMED: begin
                if (fall) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    sum_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else if (fall) begin
                    cnt_d = '0;
                    sum_d = sum_q + SUM_W'(cnt_inc);
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd0) begin
                        iv0_d = cnt_inc;
                    end else if (diff > tol) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        code_d  = ERR_MISMATCH;
                    end else if (idx_q == 2'd3) begin
                        state_d = CALC;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CALC: begin
                state_d = IDLE;
                if (div_bad) begin
                    err_d  = 1'b1;
                    code_d = ERR_RANGE;
                end else begin
                    divisor_d = div_wide[DIV_W-1:0];
                    load_d    = 1'b1;
                    locked_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Priority, lowest to highest: abort, start, software write.
        if (abort_i && (state_q == ARMED || state_q == MEASURE)) begin
            state_d = IDLE;
        end

        if (start_i) begin
            state_d = ARMED;
            cnt_d   = '0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end

        if (sw_we_i) begin
            state_d   = IDLE;
            divisor_d = divisor_o;
            locked_d  = locked_o;
            load_d    = 1'b0;
            if (sw_div_i == '0) begin
                err_d  = 1'b1;
                code_d = ERR_RANGE;
            end else begin
                divisor_d = sw_div_i;
                load_d    = 1'b1;
                locked_d  = 1'b0;
                err_d     = 1'b0;
                code_d    = ERR_NONE;
            end
        end

        busy_d = (state_d == ARMED) || (state_d == MEASURE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            iv0_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            divisor_o  <= DIV_W'(DEFAULT_DIV);
            div_load_o <= 1'b0;
            busy_o     <= 1'b0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iv0_q      <= iv0_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            divisor_o  <= divisor_d;
            div_load_o <= load_d;
            busy_o     <= busy_d;
            locked_o   <= locked_d;
            err_o      <= err_d;
            err_code_o <= code_d;
        end
    end

endmodule
